// File: rtl/snake_move_checker.sv
// snake_move_checker: owns the snake body, computes the next head from the
// requested direction, applies the wall or wrap rule, scans the body one
// segment per cycle for self-collision, then commits the move or ends the game.
module snake_move_checker #(
  parameter int unsigned COORD_BITS = 3,
  parameter int unsigned COLS       = 8,
  parameter int unsigned ROWS       = 8,
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned WRAP_MODE  = 0,
  parameter logic [2*COORD_BITS-1:0] INIT_POS = {3'd3, 3'd3}
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               restart,
  input  logic                               move_req,
  input  logic [1:0]                         direction,
  input  logic                               grow,
  output logic                               busy,
  output logic                               done,
  output logic                               collide_wall,
  output logic                               collide_self,
  output logic                               game_over,
  output logic [2*COORD_BITS-1:0]            head,
  output logic [$clog2(MAX_LEN+1)-1:0]       length
);

  localparam int unsigned POS_W = 2 * COORD_BITS;
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W = $clog2(MAX_LEN);

  localparam logic [COORD_BITS-1:0] COL_MAX = COORD_BITS'(COLS - 1);
  localparam logic [COORD_BITS-1:0] ROW_MAX = COORD_BITS'(ROWS - 1);
  localparam logic [COORD_BITS-1:0] ONE_C   = COORD_BITS'(1);
  localparam logic [LEN_W-1:0]      LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]      LEN_ONE = LEN_W'(1);
  localparam logic [IDX_W-1:0]      IDX_ONE = IDX_W'(1);
  localparam logic                  WALLS   = (WRAP_MODE == 0);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state;
  logic [POS_W-1:0]  seg [MAX_LEN];
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  n_r;
  logic [IDX_W-1:0]  idx;
  logic [POS_W-1:0]  next_head_r;
  logic              grow_r;

  logic [COORD_BITS-1:0] cur_row, cur_col, nxt_row, nxt_col;
  logic [POS_W-1:0]      next_pos;
  logic                  wall;
  logic                  growing;
  logic [LEN_W-1:0]      scan_n;
  logic                  accept;
  logic                  match;
  logic                  idx_last;
  logic                  do_commit;
  logic [POS_W-1:0]      commit_pos;
  logic                  commit_grow;

  // Next head from the current head and direction, with wall detection or wrap
  always_comb begin
    cur_row = seg[0][POS_W-1:COORD_BITS];
    cur_col = seg[0][COORD_BITS-1:0];
    nxt_row = cur_row;
    nxt_col = cur_col;
    wall    = 1'b0;
    case (direction)
      2'b00: begin
        if (cur_col == COL_MAX) begin
          wall    = WALLS;
          nxt_col = '0;
        end else begin
          nxt_col = cur_col + ONE_C;
        end
      end
      2'b01: begin
        if (cur_row == ROW_MAX) begin
          wall    = WALLS;
          nxt_row = '0;
        end else begin
          nxt_row = cur_row + ONE_C;
        end
      end
      2'b10: begin
        if (cur_col == '0) begin
          wall    = WALLS;
          nxt_col = COL_MAX;
        end else begin
          nxt_col = cur_col - ONE_C;
        end
      end
      default: begin
        if (cur_row == '0) begin
          wall    = WALLS;
          nxt_row = ROW_MAX;
        end else begin
          nxt_row = cur_row - ONE_C;
        end
      end
    endcase
    next_pos = {nxt_row, nxt_col};
  end

  // Scan length, scan progress and commit selection
  always_comb begin
    accept   = (state == IDLE) && move_req && !game_over;
    growing  = grow && (len_r < LEN_MAX);
    // a non-growing move vacates the tail, so it never counts as a hit
    scan_n   = growing ? len_r : (len_r - LEN_ONE);
    match    = (next_head_r == seg[idx]);
    idx_last = (LEN_W'(idx) == (n_r - LEN_ONE));
    do_commit   = 1'b0;
    commit_pos  = next_head_r;
    commit_grow = grow_r;
    if (state == IDLE) begin
      do_commit   = accept && !wall && (scan_n == '0);
      commit_pos  = next_pos;
      commit_grow = growing;
    end else if (state == SCAN) begin
      do_commit = !match && idx_last;
    end
  end

  // Move FSM with body store; outputs are registered
  always_ff @(posedge clock) begin
    if (reset || restart) begin
      state        <= IDLE;
      seg[0]       <= INIT_POS;
      len_r        <= LEN_ONE;
      n_r          <= '0;
      idx          <= '0;
      next_head_r  <= '0;
      grow_r       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      collide_wall <= 1'b0;
      collide_self <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      if (do_commit) begin
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
          seg[i] <= seg[i-1];
        end
        seg[0] <= commit_pos;
        if (commit_grow) begin
          len_r <= len_r + LEN_ONE;
        end
      end
      case (state)
        IDLE: begin
          if (accept) begin
            next_head_r  <= next_pos;
            grow_r       <= growing;
            n_r          <= scan_n;
            idx          <= '0;
            collide_wall <= 1'b0;
            collide_self <= 1'b0;
            busy         <= 1'b1;
            if (wall) begin
              collide_wall <= 1'b1;
              game_over    <= 1'b1;
              done         <= 1'b1;
              state        <= DONE;
            end else if (scan_n == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (match) begin
            collide_self <= 1'b1;
            game_over    <= 1'b1;
            done         <= 1'b1;
            state        <= DONE;
          end else if (idx_last) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + IDX_ONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign head   = seg[0];
  assign length = len_r;

endmodule

// File: tb/tb_snake_move_checker.sv
// Scoreboard bench for snake_move_checker: three parameter sets share one
// stimulus stream; a reference model predicts each done pulse.
module tb_snake_move_checker;

  logic clock = 1'b0;
  logic reset, restart, move_req, grow;
  logic [1:0] direction;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic       busy_a, done_a, cw_a, cs_a, go_a;
  logic [5:0] head_a;
  logic [4:0] len_a;
  logic       busy_b, done_b, cw_b, cs_b, go_b;
  logic [7:0] head_b;
  logic [2:0] len_b;
  logic       busy_c, done_c, cw_c, cs_c, go_c;
  logic [7:0] head_c;
  logic [1:0] len_c;

  snake_move_checker u_a (
    .clock(clock), .reset(reset), .restart(restart), .move_req(move_req),
    .direction(direction), .grow(grow), .busy(busy_a), .done(done_a),
    .collide_wall(cw_a), .collide_self(cs_a), .game_over(go_a),
    .head(head_a), .length(len_a));

  snake_move_checker #(.COORD_BITS(4), .COLS(10), .ROWS(6), .MAX_LEN(6),
                       .WRAP_MODE(1), .INIT_POS(8'h33)) u_b (
    .clock(clock), .reset(reset), .restart(restart), .move_req(move_req),
    .direction(direction), .grow(grow), .busy(busy_b), .done(done_b),
    .collide_wall(cw_b), .collide_self(cs_b), .game_over(go_b),
    .head(head_b), .length(len_b));

  snake_move_checker #(.COORD_BITS(4), .COLS(10), .ROWS(6), .MAX_LEN(2),
                       .WRAP_MODE(0), .INIT_POS(8'h33)) u_c (
    .clock(clock), .reset(reset), .restart(restart), .move_req(move_req),
    .direction(direction), .grow(grow), .busy(busy_c), .done(done_c),
    .collide_wall(cw_c), .collide_self(cs_c), .game_over(go_c),
    .head(head_c), .length(len_c));

  localparam int COLS_C[3] = '{8, 10, 10};
  localparam int ROWS_C[3] = '{8, 6, 6};
  localparam int ML_C[3]   = '{16, 6, 2};
  localparam int WRAP_C[3] = '{0, 1, 0};

  typedef struct {int cyc; int hr; int hc; int len; int cw; int cs; int go;} exp_t;
  typedef struct {int hr; int hc; int len; int done; int busy; int cw; int cs; int go;} snap_t;

  exp_t sb[3][$];
  int   br[3][16];
  int   bc[3][16];
  int   blen[3];
  bit   bgo[3];
  int   checks = 0;
  int   errors = 0;
  exp_t mon_e;
  snap_t mon_s;

  function automatic snap_t snap(int i);
    snap_t s;
    case (i)
      0: s = '{int'(head_a[5:3]), int'(head_a[2:0]), int'(len_a), int'(done_a),
               int'(busy_a), int'(cw_a), int'(cs_a), int'(go_a)};
      1: s = '{int'(head_b[7:4]), int'(head_b[3:0]), int'(len_b), int'(done_b),
               int'(busy_b), int'(cw_b), int'(cs_b), int'(go_b)};
      default: s = '{int'(head_c[7:4]), int'(head_c[3:0]), int'(len_c), int'(done_c),
                     int'(busy_c), int'(cw_c), int'(cs_c), int'(go_c)};
    endcase
    return s;
  endfunction

  function automatic int pending();
    return sb[0].size() + sb[1].size() + sb[2].size();
  endfunction

  task automatic chk(input string nm, input int i, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d, expected %0d (t=%0t)", nm, i, act, want, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding prediction
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      mon_s = snap(i);
      if (mon_s.done == 1) begin
        if (sb[i].size() == 0) begin
          chk("unexpected_done", i, 1, 0);
        end else begin
          mon_e = sb[i].pop_front();
          chk("done_cycle", i, cyc, mon_e.cyc);
          chk("head_row", i, mon_s.hr, mon_e.hr);
          chk("head_col", i, mon_s.hc, mon_e.hc);
          chk("length", i, mon_s.len, mon_e.len);
          chk("collide_wall", i, mon_s.cw, mon_e.cw);
          chk("collide_self", i, mon_s.cs, mon_e.cs);
          chk("game_over", i, mon_s.go, mon_e.go);
          chk("busy_in_done", i, mon_s.busy, 1);
        end
      end
    end
  end

  // Reference: position lists with plain arithmetic
  task automatic model_move(input int i, input int dir, input int g, input int c0,
                            input bit abort);
    int nr, nc, n, hit, growing;
    exp_t e;
    if (bgo[i]) return;
    nr = br[i][0];
    nc = bc[i][0];
    case (dir)
      0: nc = nc + 1;
      1: nr = nr + 1;
      2: nc = nc - 1;
      default: nr = nr - 1;
    endcase
    e.cw = 0; e.cs = 0; e.go = 0; e.cyc = 0;
    if (WRAP_C[i] != 0) begin
      nc = (nc + COLS_C[i]) % COLS_C[i];
      nr = (nr + ROWS_C[i]) % ROWS_C[i];
    end
    if (nc < 0 || nc >= COLS_C[i] || nr < 0 || nr >= ROWS_C[i]) begin
      e.cw = 1; e.go = 1; e.cyc = c0 + 1;
    end else begin
      growing = (g != 0 && blen[i] < ML_C[i]) ? 1 : 0;
      n = (growing != 0) ? blen[i] : blen[i] - 1;
      hit = -1;
      for (int k = 0; k < n; k++)
        if (hit < 0 && br[i][k] == nr && bc[i][k] == nc) hit = k;
      if (hit >= 0) begin
        e.cs = 1; e.go = 1; e.cyc = c0 + hit + 2;
      end else begin
        e.cyc = c0 + ((n == 0) ? 1 : n + 1);
        for (int k = 15; k >= 1; k--) begin
          br[i][k] = br[i][k-1];
          bc[i][k] = bc[i][k-1];
        end
        br[i][0] = nr;
        bc[i][0] = nc;
        blen[i] = blen[i] + growing;
      end
    end
    bgo[i] = (e.go != 0);
    e.hr = br[i][0];
    e.hc = bc[i][0];
    e.len = blen[i];
    if (!abort || e.cyc == c0 + 1) sb[i].push_back(e);
  endtask

  task automatic reset_models_and_check();
    snap_t s;
    for (int i = 0; i < 3; i++) begin
      br[i][0] = 3; bc[i][0] = 3; blen[i] = 1; bgo[i] = 1'b0;
      sb[i].delete();
      s = snap(i);
      chk("rst_head_row", i, s.hr, 3);
      chk("rst_head_col", i, s.hc, 3);
      chk("rst_length", i, s.len, 1);
      chk("rst_game_over", i, s.go, 0);
      chk("rst_busy", i, s.busy, 0);
      chk("rst_done", i, s.done, 0);
      chk("rst_collide_wall", i, s.cw, 0);
      chk("rst_collide_self", i, s.cs, 0);
    end
  endtask

  task automatic do_restart();
    @(posedge clock); #1;
    restart = 1'b1;
    @(posedge clock); #1;
    restart = 1'b0;
    reset_models_and_check();
  endtask

  task automatic do_move(input int dir, input int g, input bit abort);
    int c0;
    @(posedge clock); #1;
    c0 = cyc;
    direction = dir[1:0];
    grow = g[0];
    move_req = 1'b1;
    for (int i = 0; i < 3; i++) model_move(i, dir, g, c0, abort);
    @(posedge clock); #1;
    move_req = 1'b0;
    if (abort) begin
      restart = 1'b1;
      @(posedge clock); #1;
      restart = 1'b0;
    end
    for (int t = 0; t < 40 && pending() != 0; t++) @(posedge clock);
    if (pending() != 0) begin
      chk("done_timeout", 0, pending(), 0);
      for (int i = 0; i < 3; i++) sb[i].delete();
    end
    if (abort) reset_models_and_check();
  endtask

  // Directed prefix: dir + 4*grow, -1 = restart
  localparam int NDIR = 33;
  localparam int DSEQ[NDIR] = '{0, 0, 0, 0, 0, 0, 0, 0, -1,
                                1, 1, 1, -1,
                                4, 5, 6, 7, -1,
                                4, 5, 6, 3, -1,
                                4, 6, -1,
                                3, 3, 3, 3, -1,
                                4, 4};

  initial begin
    reset = 1'b1; restart = 1'b0; move_req = 1'b0; direction = 2'b00; grow = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    reset_models_and_check();
    for (int d = 0; d < NDIR; d++) begin
      if (DSEQ[d] < 0) do_restart();
      else do_move(DSEQ[d] % 4, DSEQ[d] / 4, 1'b0);
    end
    do_move(1, 1, 1'b1);
    for (int it = 0; it < 250; it++) begin
      if ((bgo[0] && bgo[1] && bgo[2]) || $urandom_range(0, 19) == 0) do_restart();
      do_move(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
              $urandom_range(0, 9) == 0);
    end
    repeat (4) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
